des_key_schedule: RTL and testbench



---
 rtl/des_pkg.sv | 57 +++++
 rtl/des_pc2.sv | 20 ++
 rtl/des_key_schedule.sv | 127 ++++++++++++
 tb/tb_des_key_schedule.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_pkg
// Description : DES key-schedule widths, PC-1/PC-2 tables, shift schedule
//               and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Entries are DES bit numbers (1 = MSB of the source vector).
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFTS [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] v,
                                                 input logic [1:0]        n);
        return (n == 2'd2) ? {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]}
                           : {v[HALF_W-2:0], v[HALF_W-1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
// Module      : des_pc2
// Description : DES permuted choice 2 (56-bit C||D -> 48-bit subkey).
// Revision    : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     cd,
    output logic [SUBKEY_W-1:0] subkey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
        localparam int SRC = CD_W - PC2[i];
        assign subkey[SUBKEY_W-1-i] = cd[SRC];
    end

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : des_key_schedule
// Description : Iterative DES key schedule, one subkey per cycle into a
//               16-entry bank, optional reversed (decrypt) ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key,
    input  logic                key_valid,
    input  logic                decrypt,
    output logic                key_ready,
    output logic                busy,
    output logic                sched_valid,
    output logic [SUBKEY_W-1:0] key_schdl_0,
    output logic [SUBKEY_W-1:0] key_schdl_1,
    output logic [SUBKEY_W-1:0] key_schdl_2,
    output logic [SUBKEY_W-1:0] key_schdl_3,
    output logic [SUBKEY_W-1:0] key_schdl_4,
    output logic [SUBKEY_W-1:0] key_schdl_5,
    output logic [SUBKEY_W-1:0] key_schdl_6,
    output logic [SUBKEY_W-1:0] key_schdl_7,
    output logic [SUBKEY_W-1:0] key_schdl_8,
    output logic [SUBKEY_W-1:0] key_schdl_9,
    output logic [SUBKEY_W-1:0] key_schdl_10,
    output logic [SUBKEY_W-1:0] key_schdl_11,
    output logic [SUBKEY_W-1:0] key_schdl_12,
    output logic [SUBKEY_W-1:0] key_schdl_13,
    output logic [SUBKEY_W-1:0] key_schdl_14,
    output logic [SUBKEY_W-1:0] key_schdl_15
);

    state_t              r_state;
    state_t              w_next_state;
    logic [HALF_W-1:0]   r_c;
    logic [HALF_W-1:0]   r_d;
    logic [3:0]          r_round;
    logic                r_dec;
    logic                r_sched_valid;
    logic [SUBKEY_W-1:0] r_bank [0:ROUNDS-1];

    logic [CD_W-1:0]     w_pc1;
    logic [HALF_W-1:0]   w_c_rot;
    logic [HALF_W-1:0]   w_d_rot;
    logic [SUBKEY_W-1:0] w_subkey;
    logic [3:0]          w_idx;
    logic                w_accept;

    // PC-1 drops the parity bits; key bit 63 is DES bit 1.
    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        localparam int SRC = KEY_W - PC1[i];
        assign w_pc1[CD_W-1-i] = key[SRC];
    end

    assign w_c_rot  = rotl28(r_c, SHIFTS[r_round]);
    assign w_d_rot  = rotl28(r_d, SHIFTS[r_round]);
    assign w_idx    = r_dec ? ~r_round : r_round;
    assign w_accept = key_valid && key_ready;

    des_pc2 u_pc2 (
        .cd     ({w_c_rot, w_d_rot}),
        .subkey (w_subkey)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (w_accept) w_next_state = GEN;
            GEN:        if (r_round == 4'd15) w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_c           <= '0;
            r_d           <= '0;
            r_round       <= '0;
            r_dec         <= 1'b0;
            r_sched_valid <= 1'b0;
            for (int i = 0; i < ROUNDS; i++) r_bank[i] <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_c           <= w_pc1[CD_W-1:HALF_W];
                r_d           <= w_pc1[HALF_W-1:0];
                r_round       <= '0;
                r_dec         <= decrypt;
                r_sched_valid <= 1'b0;
            end else if (r_state == GEN) begin
                r_c           <= w_c_rot;
                r_d           <= w_d_rot;
                r_round       <= r_round + 4'd1;
                r_bank[w_idx] <= w_subkey;
                if (r_round == 4'd15) r_sched_valid <= 1'b1;
            end
        end
    end

    assign key_ready   = (r_state != GEN);
    assign busy        = (r_state == GEN);
    assign sched_valid = r_sched_valid;

    assign key_schdl_0  = r_bank[0];
    assign key_schdl_1  = r_bank[1];
    assign key_schdl_2  = r_bank[2];
    assign key_schdl_3  = r_bank[3];
    assign key_schdl_4  = r_bank[4];
    assign key_schdl_5  = r_bank[5];
    assign key_schdl_6  = r_bank[6];
    assign key_schdl_7  = r_bank[7];
    assign key_schdl_8  = r_bank[8];
    assign key_schdl_9  = r_bank[9];
    assign key_schdl_10 = r_bank[10];
    assign key_schdl_11 = r_bank[11];
    assign key_schdl_12 = r_bank[12];
    assign key_schdl_13 = r_bank[13];
    assign key_schdl_14 = r_bank[14];
    assign key_schdl_15 = r_bank[15];

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_key_schedule
// Description : Directed self-checking bench for des_key_schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_A_P = 64'h123556789ABDDEF0;
    localparam logic [63:0] WEAK_0  = 64'h0101010101010101;
    localparam logic [63:0] WEAK_1  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [47:0] K1      = 48'h1B02EFFC7072;
    localparam logic [47:0] K2      = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16     = 48'hCB3D8B0E17F5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] key = '0;
    logic        key_valid = 1'b0;
    logic        decrypt = 1'b0;
    logic        key_ready, busy, sched_valid;
    logic [47:0] ks [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .key_valid    (key_valid),
        .decrypt      (decrypt),
        .key_ready    (key_ready),
        .busy         (busy),
        .sched_valid  (sched_valid),
        .key_schdl_0  (ks[0]),
        .key_schdl_1  (ks[1]),
        .key_schdl_2  (ks[2]),
        .key_schdl_3  (ks[3]),
        .key_schdl_4  (ks[4]),
        .key_schdl_5  (ks[5]),
        .key_schdl_6  (ks[6]),
        .key_schdl_7  (ks[7]),
        .key_schdl_8  (ks[8]),
        .key_schdl_9  (ks[9]),
        .key_schdl_10 (ks[10]),
        .key_schdl_11 (ks[11]),
        .key_schdl_12 (ks[12]),
        .key_schdl_13 (ks[13]),
        .key_schdl_14 (ks[14]),
        .key_schdl_15 (ks[15])
    );

    task automatic check_value(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accepts one key, waits for sched_valid (bounded) and reports latency
    // plus the number of post-edge samples with key_ready low.
    task automatic run_schedule(input logic [63:0] k, input logic dec,
                                output int latency, output int ready_low);
        key       = k;
        decrypt   = dec;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        decrypt   = 1'b0;
        latency   = 0;
        ready_low = key_ready ? 0 : 1;
        check_value("valid_falls_on_accept", {63'd0, sched_valid}, 64'd0);
        while (!sched_valid && latency < 40) begin
            @(posedge clk); #1;
            latency++;
            if (!key_ready) ready_low++;
        end
    endtask

    initial begin
        int lat, rlow;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_value("reset_key_ready", {63'd0, key_ready}, 64'd1);
        check_value("reset_busy", {63'd0, busy}, 64'd0);
        check_value("reset_sched_valid", {63'd0, sched_valid}, 64'd0);
        check_value("reset_ks0", {16'd0, ks[0]}, 64'd0);
        check_value("reset_ks15", {16'd0, ks[15]}, 64'd0);

        run_schedule(KEY_A, 1'b0, lat, rlow);
        check_value("enc_latency", 64'(lat), 64'd16);
        check_value("enc_ks0", {16'd0, ks[0]}, {16'd0, K1});
        check_value("enc_ks1", {16'd0, ks[1]}, {16'd0, K2});
        check_value("enc_ks15", {16'd0, ks[15]}, {16'd0, K16});
        repeat (5) @(posedge clk);
        #1;
        check_value("done_stable_ks0", {16'd0, ks[0]}, {16'd0, K1});
        check_value("done_key_ready", {63'd0, key_ready}, 64'd1);

        run_schedule(KEY_A, 1'b1, lat, rlow);
        check_value("dec_latency", 64'(lat), 64'd16);
        check_value("dec_ks0", {16'd0, ks[0]}, {16'd0, K16});
        check_value("dec_ks14", {16'd0, ks[14]}, {16'd0, K2});
        check_value("dec_ks15", {16'd0, ks[15]}, {16'd0, K1});

        run_schedule(WEAK_0, 1'b0, lat, rlow);
        for (int i = 0; i < 16; i++)
            check_value($sformatf("weak0_ks%0d", i), {16'd0, ks[i]}, 64'd0);

        run_schedule(WEAK_1, 1'b0, lat, rlow);
        for (int i = 0; i < 16; i++)
            check_value($sformatf("weak1_ks%0d", i), {16'd0, ks[i]},
                        64'h0000FFFFFFFFFFFF);

        run_schedule(KEY_A_P, 1'b0, lat, rlow);
        check_value("parity_ks0", {16'd0, ks[0]}, {16'd0, K1});
        check_value("parity_ks1", {16'd0, ks[1]}, {16'd0, K2});
        check_value("parity_ks15", {16'd0, ks[15]}, {16'd0, K16});

        // Reset part-way through generation.
        key = KEY_A; decrypt = 1'b0; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_value("midrst_sched_valid", {63'd0, sched_valid}, 64'd0);
        check_value("midrst_key_ready", {63'd0, key_ready}, 64'd1);
        check_value("midrst_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 16; i++)
            check_value($sformatf("midrst_ks%0d", i), {16'd0, ks[i]}, 64'd0);
        run_schedule(KEY_A, 1'b0, lat, rlow);
        check_value("post_rst_latency", 64'(lat), 64'd16);
        check_value("post_rst_ks0", {16'd0, ks[0]}, {16'd0, K1});
        check_value("post_rst_ks15", {16'd0, ks[15]}, {16'd0, K16});

        // Competing request during GEN must be dropped.
        run_schedule(WEAK_0, 1'b0, lat, rlow);
        key = KEY_A; decrypt = 1'b0; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        key = WEAK_1; decrypt = 1'b1; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; decrypt = 1'b0;
        lat = 0;
        while (!sched_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_value("ignore_sched_valid", {63'd0, sched_valid}, 64'd1);
        check_value("ignore_ks0", {16'd0, ks[0]}, {16'd0, K1});
        check_value("ignore_ks15", {16'd0, ks[15]}, {16'd0, K16});
        repeat (2) @(posedge clk);
        #1;
        check_value("ignore_no_restart", {63'd0, busy}, 64'd0);

        // Back-to-back from DONE.
        run_schedule(KEY_A, 1'b1, lat, rlow);
        check_value("b2b_latency", 64'(lat), 64'd16);
        check_value("b2b_ready_low", 64'(rlow), 64'd16);
        check_value("b2b_ks0", {16'd0, ks[0]}, {16'd0, K16});
        check_value("b2b_ks15", {16'd0, ks[15]}, {16'd0, K1});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
